// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - three-way VRAM arbiter (screen, CPU, ULAplus palette) driving an async SRAM
// Each access is SETUP, ACC_CYCLES of STROBE, then HOLD; arbitration happens in IDLE and HOLD.
module vram_arbiter #(
  parameter int ACC_CYCLES = 2,
  parameter int MAX_WAIT   = 8
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        scr_req,
  input  logic [18:0] scr_addr,
  output logic        scr_gnt,
  output logic        scr_done,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_done,
  input  logic        up_req,
  input  logic [18:0] up_addr,
  input  logic [7:0]  up_wdata,
  output logic        up_gnt,
  output logic        up_done,
  output logic [7:0]  rdata,
  output logic [18:0] va,
  output logic [7:0]  vd_o,
  output logic        vd_oe,
  input  logic [7:0]  vd_i,
  output logic        n_vrd,
  output logic        n_vwr,
  output logic        busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [1:0] LAST_CNT = 2'(ACC_CYCLES - 1);
  localparam logic [3:0] MAX_CNT  = 4'(MAX_WAIT);

  logic [1:0]  r_state;
  logic [1:0]  r_cnt;
  logic [2:0]  r_own;
  logic [18:0] r_addr;
  logic        r_we;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic [3:0]  r_up_wait;

  logic        w_arb;
  logic        w_busy;
  logic        w_up_hi;
  logic [2:0]  w_win;
  logic [18:0] w_addr;
  logic        w_we;
  logic [7:0]  w_wdata;

  assign w_arb   = (r_state == S_IDLE) || (r_state == S_HOLD);
  assign w_busy  = (r_state != S_IDLE);
  assign w_up_hi = up_req && (r_up_wait == MAX_CNT);

  // Winner one-hot {up, cpu, scr}; a starved up request jumps ahead of cpu only.
  always_comb begin
    w_win   = 3'b000;
    w_addr  = r_addr;
    w_we    = 1'b0;
    w_wdata = 8'h00;
    if (scr_req) begin
      w_win  = 3'b001;
      w_addr = scr_addr;
    end else if (w_up_hi) begin
      w_win   = 3'b100;
      w_addr  = up_addr;
      w_we    = 1'b1;
      w_wdata = up_wdata;
    end else if (cpu_req) begin
      w_win   = 3'b010;
      w_addr  = cpu_addr;
      w_we    = cpu_we;
      w_wdata = cpu_wdata;
    end else if (up_req) begin
      w_win   = 3'b100;
      w_addr  = up_addr;
      w_we    = 1'b1;
      w_wdata = up_wdata;
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_own   <= 3'b000;
      r_addr  <= 19'd0;
      r_we    <= 1'b0;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (|w_win) begin
            r_state <= S_SETUP;
            r_own   <= w_win;
            r_addr  <= w_addr;
            r_we    <= w_we;
            r_wdata <= w_wdata;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SETUP: begin
          r_state <= S_STROBE;
          r_cnt   <= 2'd0;
        end
        default: begin
          if (r_cnt == LAST_CNT) begin
            r_state <= S_HOLD;
            if (!r_we) r_rdata <= vd_i;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      r_up_wait <= 4'd0;
    end else if (w_arb && w_win[2]) begin
      r_up_wait <= 4'd0;
    end else if (up_req && !up_gnt && (r_up_wait != MAX_CNT)) begin
      r_up_wait <= r_up_wait + 4'd1;
    end
  end

  assign scr_gnt  = w_busy && r_own[0];
  assign cpu_gnt  = w_busy && r_own[1];
  assign up_gnt   = w_busy && r_own[2];
  assign scr_done = (r_state == S_HOLD) && r_own[0];
  assign cpu_done = (r_state == S_HOLD) && r_own[1];
  assign up_done  = (r_state == S_HOLD) && r_own[2];

  assign rdata = r_rdata;
  assign va    = r_addr;
  assign vd_o  = r_wdata;
  assign vd_oe = w_busy && r_we;
  assign n_vrd = !((r_state == S_STROBE) && !r_we);
  assign n_vwr = !((r_state == S_STROBE) && r_we);
  assign busy  = w_busy;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed bench for vram_arbiter with default ACC_CYCLES=2, MAX_WAIT=8
// Inputs change and outputs are sampled on the falling edge of clk28.
module tb_vram_arbiter;

  logic        clk28 = 1'b0;
  logic        rst;
  logic        scr_req, cpu_req, cpu_we, up_req;
  logic [18:0] scr_addr, cpu_addr, up_addr;
  logic [7:0]  cpu_wdata, up_wdata, vd_i;
  logic        scr_gnt, scr_done, cpu_gnt, cpu_done, up_gnt, up_done;
  logic [7:0]  rdata, vd_o;
  logic [18:0] va;
  logic        vd_oe, n_vrd, n_vwr, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk28 = ~clk28;

  vram_arbiter #(.ACC_CYCLES(2), .MAX_WAIT(8)) dut (
    .clk28(clk28), .rst(rst),
    .scr_req(scr_req), .scr_addr(scr_addr), .scr_gnt(scr_gnt), .scr_done(scr_done),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
    .up_req(up_req), .up_addr(up_addr), .up_wdata(up_wdata), .up_gnt(up_gnt), .up_done(up_done),
    .rdata(rdata), .va(va), .vd_o(vd_o), .vd_oe(vd_oe), .vd_i(vd_i),
    .n_vrd(n_vrd), .n_vwr(n_vwr), .busy(busy)
  );

  task automatic test_reset;
    rst = 1'b1;
    scr_req = 0; cpu_req = 0; cpu_we = 0; up_req = 0;
    scr_addr = 19'h00111; cpu_addr = 0; up_addr = 0;
    cpu_wdata = 0; up_wdata = 0; vd_i = 8'hEE;
    repeat (3) @(negedge clk28);
    n_cmp++; if (n_vrd !== 1'b1) begin n_bad++; $display("FAIL reset_n_vrd got %b want 1", n_vrd); end
    n_cmp++; if (n_vwr !== 1'b1) begin n_bad++; $display("FAIL reset_n_vwr got %b want 1", n_vwr); end
    n_cmp++; if (vd_oe !== 1'b0) begin n_bad++; $display("FAIL reset_vd_oe got %b want 0", vd_oe); end
    n_cmp++; if (va !== 19'd0) begin n_bad++; $display("FAIL reset_va got %h want 0", va); end
    n_cmp++; if (vd_o !== 8'd0) begin n_bad++; $display("FAIL reset_vd_o got %h want 0", vd_o); end
    n_cmp++; if (rdata !== 8'd0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_cmp++; if ({scr_gnt, cpu_gnt, up_gnt, scr_done, cpu_done, up_done} !== 6'b0) begin
      n_bad++; $display("FAIL reset_gnt_done got %b want 000000", {scr_gnt, cpu_gnt, up_gnt, scr_done, cpu_done, up_done});
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (dut.r_up_wait !== 4'd0) begin n_bad++; $display("FAIL reset_wait got %0d want 0", dut.r_up_wait); end
    rst = 1'b0;
    @(negedge clk28);
  endtask

  task automatic test_cpu_read;
    int lo;
    lo = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'h12345; vd_i = 8'hA5;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk28);
      if (!n_vrd) lo++;
      n_cmp++; if (va !== 19'h12345) begin n_bad++; $display("FAIL rd_va cyc %0d got %h want 12345", i, va); end
      n_cmp++; if (cpu_gnt !== 1'b1) begin n_bad++; $display("FAIL rd_gnt cyc %0d got %b want 1", i, cpu_gnt); end
      n_cmp++; if (cpu_done !== (i == 4)) begin n_bad++; $display("FAIL rd_done cyc %0d got %b want %b", i, cpu_done, i == 4); end
    end
    cpu_req = 0;
    n_cmp++; if (lo != 2) begin n_bad++; $display("FAIL rd_strobe_len got %0d want 2", lo); end
    n_cmp++; if (rdata !== 8'hA5) begin n_bad++; $display("FAIL rd_rdata got %h want a5", rdata); end
    @(negedge clk28);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_idle_busy got %b want 0", busy); end
    n_cmp++; if (cpu_done !== 1'b0) begin n_bad++; $display("FAIL rd_done_after got %b want 0", cpu_done); end
  endtask

  task automatic test_back_to_back;
    int sd, cd;
    sd = 0; cd = 0;
    scr_req = 1; scr_addr = 19'h00200; cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00300;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk28);
      if (scr_done) sd++;
      if (cpu_done) cd++;
      if (i <= 4) begin
        n_cmp++; if ({scr_gnt, cpu_gnt} !== 2'b10) begin n_bad++; $display("FAIL b2b_scr_first cyc %0d got %b want 10", i, {scr_gnt, cpu_gnt}); end
      end
      if (i == 4) scr_req = 0;
      if (i == 5) begin
        n_cmp++; if ({busy, scr_gnt, cpu_gnt} !== 3'b101) begin n_bad++; $display("FAIL b2b_no_gap got %b want 101", {busy, scr_gnt, cpu_gnt}); end
        n_cmp++; if (va !== 19'h00300) begin n_bad++; $display("FAIL b2b_va got %h want 00300", va); end
      end
      if (i == 8) begin
        n_cmp++; if (cpu_done !== 1'b1) begin n_bad++; $display("FAIL b2b_cpu_done got %b want 1", cpu_done); end
        cpu_req = 0;
      end
    end
    n_cmp++; if (sd != 1) begin n_bad++; $display("FAIL b2b_scr_done_cnt got %0d want 1", sd); end
    n_cmp++; if (cd != 1) begin n_bad++; $display("FAIL b2b_cpu_done_cnt got %0d want 1", cd); end
  endtask

  task automatic test_up_promote;
    int cd, cyc, prev_wait;
    bit got;
    cd = 0; cyc = 0; got = 0; prev_wait = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00400;
    up_req = 1; up_addr = 19'h7FF01; up_wdata = 8'h99;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk28);
      if (up_gnt) begin got = 1; cyc = i; end
      else begin
        if (cpu_done) cd++;
        prev_wait = dut.r_up_wait;
      end
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL up_promote_timeout got no up_gnt want grant"); end
    n_cmp++; if (cyc != 9) begin n_bad++; $display("FAIL up_promote_cycle got %0d want 9", cyc); end
    n_cmp++; if (cd != 2) begin n_bad++; $display("FAIL up_promote_cpu_done got %0d want 2", cd); end
    n_cmp++; if (prev_wait != 8) begin n_bad++; $display("FAIL up_wait_sat got %0d want 8", prev_wait); end
    n_cmp++; if (dut.r_up_wait !== 4'd0) begin n_bad++; $display("FAIL up_wait_clear got %0d want 0", dut.r_up_wait); end
    n_cmp++; if (cpu_gnt !== 1'b0) begin n_bad++; $display("FAIL up_promote_cpu_gnt got %b want 0", cpu_gnt); end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk28);
      if (up_done) begin got = 1; up_req = 0; end
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL up_done_timeout got no up_done want pulse"); end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk28);
      if (cpu_done) begin got = 1; cpu_req = 0; end
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL cpu_resume_timeout got no cpu_done want pulse"); end
    @(negedge clk28);
  endtask

  task automatic test_up_write;
    int oe, wl;
    oe = 0; wl = 0;
    vd_i = 8'h11;
    up_req = 1; up_addr = 19'h7FF00; up_wdata = 8'h3C;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk28);
      if (vd_oe) oe++;
      if (!n_vwr) wl++;
      n_cmp++; if (vd_o !== 8'h3C) begin n_bad++; $display("FAIL wr_vd_o cyc %0d got %h want 3c", i, vd_o); end
      n_cmp++; if (n_vwr !== !(i == 2 || i == 3)) begin n_bad++; $display("FAIL wr_n_vwr cyc %0d got %b want %b", i, n_vwr, !(i == 2 || i == 3)); end
      n_cmp++; if (n_vrd !== 1'b1) begin n_bad++; $display("FAIL wr_n_vrd cyc %0d got %b want 1", i, n_vrd); end
    end
    n_cmp++; if (up_done !== 1'b1) begin n_bad++; $display("FAIL wr_up_done got %b want 1", up_done); end
    up_req = 0;
    @(negedge clk28);
    n_cmp++; if (oe != 4) begin n_bad++; $display("FAIL wr_oe_len got %0d want 4", oe); end
    n_cmp++; if (wl != 2) begin n_bad++; $display("FAIL wr_strobe_len got %0d want 2", wl); end
    n_cmp++; if (vd_oe !== 1'b0) begin n_bad++; $display("FAIL wr_oe_after got %b want 0", vd_oe); end
    n_cmp++; if (rdata !== 8'hA5) begin n_bad++; $display("FAIL wr_rdata got %h want a5", rdata); end
  endtask

  task automatic test_reset_abort;
    int dn;
    dn = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 19'h01234; cpu_wdata = 8'h5A;
    repeat (2) @(negedge clk28);
    n_cmp++; if (n_vwr !== 1'b0) begin n_bad++; $display("FAIL abort_strobe got %b want 0", n_vwr); end
    rst = 1; cpu_req = 0;
    @(negedge clk28);
    n_cmp++; if (n_vwr !== 1'b1) begin n_bad++; $display("FAIL abort_n_vwr got %b want 1", n_vwr); end
    n_cmp++; if (vd_oe !== 1'b0) begin n_bad++; $display("FAIL abort_vd_oe got %b want 0", vd_oe); end
    n_cmp++; if ({scr_gnt, cpu_gnt, up_gnt} !== 3'b0) begin n_bad++; $display("FAIL abort_gnt got %b want 000", {scr_gnt, cpu_gnt, up_gnt}); end
    if (cpu_done) dn++;
    rst = 0;
    repeat (3) begin
      @(negedge clk28);
      if (cpu_done) dn++;
    end
    n_cmp++; if (dn != 0) begin n_bad++; $display("FAIL abort_done got %0d want 0", dn); end
  endtask

  task automatic test_drop_setup;
    int dn;
    dn = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'h05555; vd_i = 8'h77;
    @(negedge clk28);
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_bad++; $display("FAIL drop_setup_gnt got %b want 1", cpu_gnt); end
    cpu_req = 0;
    for (int i = 2; i <= 7; i++) begin
      @(negedge clk28);
      if (cpu_done) dn++;
      if (i == 4) begin
        n_cmp++; if (cpu_done !== 1'b1) begin n_bad++; $display("FAIL drop_done_cyc got %b want 1", cpu_done); end
      end
    end
    n_cmp++; if (dn != 1) begin n_bad++; $display("FAIL drop_done_cnt got %0d want 1", dn); end
    n_cmp++; if (rdata !== 8'h77) begin n_bad++; $display("FAIL drop_rdata got %h want 77", rdata); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_back_to_back();
    test_up_promote();
    test_up_write();
    test_reset_abort();
    test_drop_setup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
